irotator64: RTL and testbench
=============================

# irotator64

Inverse twiddle rotator between two radix-8 stages of the 64-point IFFT pipeline. It multiplies each complex sample of a 64-sample frame by the conjugate twiddle factor W64^(−n1·k2), i.e. it undoes the forward-path rotation. Twiddles come from a quarter-wave cosine table plus octant/quadrant symmetry, so no full 64-entry ROM is needed. It follows the forward path's ED/START/RDY streaming discipline and 1/2 output scaling, so the FFT and IFFT gain schedules match.

## Interface
- NB, 16, data parameter; data ports are NB+2 bits signed
- NW, 15, twiddle width, signed; unity = 2^(NW−1)−1
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- ED  in  1  enable; when low, every register holds
- START  in  1  frame-start impulse; first sample is taken on the ED edge after it
- DR, DI  in  NB+2  input real/imag, two's complement
- DOR, DOI  out  NB+2  rotated output real/imag
- RDY  out  1  one-ED-cycle pulse marking output sample 0 of a frame

## Operation
- All updates are qualified by ED=1 at the rising edge ("ED edge").
- Address counter addr[5:0]:
  - START·ED forces addr←0.
  - Otherwise each ED edge increments addr, wrapping 63→0 indefinitely.
- Twiddle exponent e = addr[5:3]·addr[2:0], range 0..49.
  - q = e[5:4], m = e[3:0]; table T[m] = round((2^(NW−1)−1)·cos(2πm/64)) for m = 0..16.
  - q0: c = T[m], s = T[16−m]
  - q1: c = −T[16−m], s = T[m]
  - q2: c = −T[m], s = −T[16−m]
  - q3: c = T[16−m], s = −T[m]
- Conjugate product:
  - DOR = (DR·c − DI·s) / 2
  - DOI = (DR·s + DI·c) / 2
- Each of the four products is NB+NW+2 bits. Each is shifted arithmetic right by NW−1 to NB+3 bits.
- The sum/difference is NB+3 bits and the output is sum[NB+2:1]. The magnitude bound (|c|,|s| < 2^(NW−1)) means the result always fits. There is no saturation logic.
- START mid-frame: addr restarts at 0 and a new RDY is scheduled. Samples already in the pipeline drain unchanged; there is no flush.
- Counter wrap without START produces no RDY.

## Timing
- Pipeline, with E0 the START edge:
  - E(k+1): sample k and registered twiddle(addr=k) captured.
  - E(k+2): products registered.
  - E(k+3): DOR/DOI registered.
- Latency is 3 ED edges from capture of a sample to its output. Output is valid in the cycle after E(k+3).
- RDY is a 3-stage shift of START·ED on ED edges. It is high from E3 until the next ED edge.
- ED low: outputs, RDY, addr and the pipeline all freeze. No twiddle index is skipped or repeated.
- Reset: addr=0, all pipeline registers 0, DOR=DOI=0, RDY=0. RST overrides START and ED. Reset mid-frame discards in-flight data.

## Configuration
- IROT_ROUND_EN defined:
  - add 2^(NW−2) to each product before the NW−1 shift;
  - add 1 to each sum before dropping the LSB (round half up).
- Undefined: pure truncation (floor) at both points, bit-identical to the forward path.

## Structure
- Shared package fft64_pkg holds:
  - NB/NW defaults;
  - the 17-entry quarter-wave table T as localparam constants;
  - the quadrant encoding.
- Sub-module twiddle_gen64: combinational addr→(c, s), i.e. the 3×3 multiply, quadrant mapping and table lookup. Its output is registered in irotator64.

## Test plan
1. Reset:
   - Stimulus: RST=1 for 2 cycles with random DR/DI/START.
   - Response: DOR=DOI=0 and RDY=0 throughout and 1 cycle after release.
2. Constant real input:
   - Stimulus: DR=1000, DI=0, START then 64 ED cycles.
   - Response: RDY high with sample 0; samples 0–8 give DOR=499, DOI=0 (truncate) or DOR=500 with IROT_ROUND_EN.
3. Quadrant check:
   - Stimulus: same stimulus as scenario 2.
   - Response: sample 36 (e=16) gives DOR=0, DOI=499; sample 20 (e=8, c=s=11585) gives DOR=353, DOI=353.
4. ED gating:
   - Stimulus: ED=0 for 5 cycles after sample 10.
   - Response: outputs/RDY held; the resumed sequence equals the ungated reference exactly.
5. Extreme values:
   - Stimulus: DR=−131072, DI=131071 at sample 20.
   - Response: DOR=−92680, DOI=−1; no wrap.
6. START mid-frame and wrap:
   - Stimulus: START after sample 10, then 130 ED cycles.
   - Response: the next sample uses e=0; RDY pulses exactly once, 3 ED edges later; no RDY at the 63→0 wrap.

Source files
------------

// File: rtl/fft64_pkg.sv
// Shared constants for the 64-point FFT/IFFT datapath: default widths,
// quarter-wave cosine table and twiddle quadrant encoding.
package fft64_pkg;

    localparam int NB_DEF = 16;
    localparam int NW_DEF = 15;

    // round((2^(NW_DEF-1)-1) * cos(2*pi*m/64)) for m = 0..16
    localparam int COS_TAB [17] = '{
        16383, 16304, 16068, 15678, 15136, 14449, 13622, 12664,
        11585, 10393,  9102,  7723,  6270,  4756,  3196,  1606,
            0
    };

    typedef enum logic [1:0] {
        QUAD0 = 2'd0,
        QUAD1 = 2'd1,
        QUAD2 = 2'd2,
        QUAD3 = 2'd3
    } quad_e;

    function automatic int cos_lut(input logic [4:0] idx);
        return COS_TAB[idx];
    endfunction

endpackage

// File: rtl/irotator64_if.sv
// Streaming sample bus between FFT stages: ED/START qualifiers in,
// rotated samples and RDY frame marker out.
interface irotator64_if import fft64_pkg::*; #(
    parameter int NB = NB_DEF
) ();
    logic                 ED;
    logic                 START;
    logic signed [NB+1:0] DR;
    logic signed [NB+1:0] DI;
    logic signed [NB+1:0] DOR;
    logic signed [NB+1:0] DOI;
    logic                 RDY;

    modport master (
        output ED, START, DR, DI,
        input  DOR, DOI, RDY
    );

    modport slave (
        input  ED, START, DR, DI,
        output DOR, DOI, RDY
    );
endinterface

// File: rtl/twiddle_gen64.sv
// Combinational twiddle generator: addr -> (cos, sin) of W64^(n1*k2) using
// the quarter-wave table and quadrant symmetry.
module twiddle_gen64 import fft64_pkg::*; #(
    parameter int NW = NW_DEF
) (
    input  logic [5:0]           addr_i,
    output logic signed [NW-1:0] c_o,
    output logic signed [NW-1:0] s_o
);
    logic [5:0] e;
    quad_e      q;
    logic [3:0] m;
    int         t_m;
    int         t_mc;
    int         c_int;
    int         s_int;

    always_comb begin
        // NOTE: every variable driven here gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        c_int = 0;
        s_int = 0;
        e     = {3'b000, addr_i[5:3]} * {3'b000, addr_i[2:0]};
        q     = quad_e'(e[5:4]);
        m     = e[3:0];
        t_m   = cos_lut({1'b0, m});
        t_mc  = cos_lut(5'd16 - {1'b0, m});
        case (q)
            QUAD0: begin c_int =  t_m;  s_int =  t_mc; end
            QUAD1: begin c_int = -t_mc; s_int =  t_m;  end
            QUAD2: begin c_int = -t_m;  s_int = -t_mc; end
            QUAD3: begin c_int =  t_mc; s_int = -t_m;  end
        endcase
    end

    assign c_o = NW'(c_int);
    assign s_o = NW'(s_int);

endmodule

// File: rtl/irotator64.sv
// Inverse twiddle rotator between radix-8 IFFT stages, 3-ED-edge latency,
// 1/2 output scaling. Define IROT_ROUND_EN for round-half-up instead of floor.
module irotator64 import fft64_pkg::*; #(
    parameter int NB = NB_DEF,
    parameter int NW = NW_DEF
) (
    input logic        CLK,
    input logic        RST,
    irotator64_if.slave bus
);
    localparam int PW = NB + NW + 2;
    localparam int SW = NB + 3;
`ifdef IROT_ROUND_EN
    localparam int P_RND = 2 ** (NW - 2);
    localparam int S_RND = 1;
`else
    localparam int P_RND = 0;
    localparam int S_RND = 0;
`endif

    logic [5:0]           addr_q, addr_d;
    logic signed [NW-1:0] c_tw, s_tw;
    logic signed [NW-1:0] c_q, s_q;
    logic signed [NB+1:0] dr_q, di_q;
    logic signed [SW-1:0] prc_q, pis_q, prs_q, pic_q;
    logic signed [SW-1:0] prc_d, pis_d, prs_d, pic_d;
    logic signed [SW-1:0] sum_r, sum_i;
    logic signed [NB+1:0] dor_q, doi_q, dor_d, doi_d;
    logic [3:0]           rdy_q, rdy_d;

    twiddle_gen64 #(.NW(NW)) u_twiddle (
        .addr_i (addr_q),
        .c_o    (c_tw),
        .s_o    (s_tw)
    );

    // Full-precision product scaled back by the twiddle unity weight.
    function automatic logic signed [SW-1:0] scale_prod(
        input logic signed [NB+1:0] x,
        input logic signed [NW-1:0] w
    );
        logic signed [PW-1:0] p;
        p = PW'(x) * PW'(w) + PW'(P_RND);
        return SW'(p >>> (NW - 1));
    endfunction

    always_comb begin
        addr_d = bus.START ? 6'd0 : addr_q + 6'd1;
        prc_d  = scale_prod(dr_q, c_q);
        pis_d  = scale_prod(di_q, s_q);
        prs_d  = scale_prod(dr_q, s_q);
        pic_d  = scale_prod(di_q, c_q);
        sum_r  = prc_q - pis_q + SW'(S_RND);
        sum_i  = prs_q + pic_q + SW'(S_RND);
        dor_d  = (NB+2)'(sum_r >>> 1);
        doi_d  = (NB+2)'(sum_i >>> 1);
        // START lands in bit 0 on the START edge and reaches bit 3 together
        // with output sample 0.
        rdy_d  = {rdy_q[2:0], bus.START};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q <= '0;
            dr_q   <= '0;
            di_q   <= '0;
            c_q    <= '0;
            s_q    <= '0;
            prc_q  <= '0;
            pis_q  <= '0;
            prs_q  <= '0;
            pic_q  <= '0;
            dor_q  <= '0;
            doi_q  <= '0;
            rdy_q  <= '0;
        end else if (bus.ED) begin
            // NOTE: state updates use non-blocking assignments so every
            // stage samples the values from before this edge.
            addr_q <= addr_d;
            dr_q   <= bus.DR;
            di_q   <= bus.DI;
            c_q    <= c_tw;
            s_q    <= s_tw;
            prc_q  <= prc_d;
            pis_q  <= pis_d;
            prs_q  <= prs_d;
            pic_q  <= pic_d;
            dor_q  <= dor_d;
            doi_q  <= doi_d;
            rdy_q  <= rdy_d;
        end
    end

    assign bus.DOR = dor_q;
    assign bus.DOI = doi_q;
    assign bus.RDY = rdy_q[3];

endmodule

// File: tb/tb_irotator64.sv
// Directed bench for irotator64: reset, constant frames, quadrant points,
// ED gating, extreme values, mid-frame START and counter wrap.
module tb_irotator64;
    localparam int    NB = 16;
    localparam int    DW = NB + 2;
    localparam real   PI = 3.14159265358979323846;
`ifdef IROT_ROUND_EN
    localparam longint PRND = 8192;
    localparam longint SRND = 1;
    localparam int     H_E0 = 500;
    localparam int     H_E8 = 354;
    localparam int     H_XR = -92679;
    localparam int     H_XI = 0;
`else
    localparam longint PRND = 0;
    localparam longint SRND = 0;
    localparam int     H_E0 = 499;
    localparam int     H_E8 = 353;
    localparam int     H_XR = -92680;
    localparam int     H_XI = -1;
`endif

    logic CLK;
    logic RST;
    irotator64_if #(.NB(NB)) bus ();

    irotator64 #(.NB(NB), .NW(15)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_checks;
    int         n_errors;
    int         tab [17];
    int         exp_r [3];
    int         exp_i [3];
    logic [3:0] exp_rdy;
    int         m_addr;
    int         rdy_hits;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural reference: conjugate product with the stated scaling.
    function automatic void model(input int a, input int dr, input int di,
                                  output int dor, output int doi);
        int e, m, c, s;
        longint rc, is_, rs, ic, sr, si;
        e = (a / 8) * (a % 8);
        m = e % 16;
        case (e / 16)
            0:       begin c =  tab[m];      s =  tab[16 - m]; end
            1:       begin c = -tab[16 - m]; s =  tab[m];      end
            2:       begin c = -tab[m];      s = -tab[16 - m]; end
            default: begin c =  tab[16 - m]; s = -tab[m];      end
        endcase
        rc  = (longint'(dr) * c + PRND) >>> 14;
        is_ = (longint'(di) * s + PRND) >>> 14;
        rs  = (longint'(dr) * s + PRND) >>> 14;
        ic  = (longint'(di) * c + PRND) >>> 14;
        sr  = rc - is_ + SRND;
        si  = rs + ic + SRND;
        dor = int'(sr >>> 1);
        doi = int'(si >>> 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            exp_r[i] = 0;
            exp_i[i] = 0;
        end
        exp_rdy = '0;
        m_addr  = 0;
    endtask

    task automatic do_reset(input logic ed, input string tag);
        RST       = 1'b1;
        bus.ED    = ed;
        bus.START = 1'($urandom_range(0, 1));
        bus.DR    = DW'($urandom_range(0, 262143));
        bus.DI    = DW'($urandom_range(0, 262143));
        @(posedge CLK);
        #1;
        model_reset();
        chk({tag, "_dor"}, bus.DOR, 0);
        chk({tag, "_doi"}, bus.DOI, 0);
        chk({tag, "_rdy"}, bus.RDY, 0);
    endtask

    task automatic do_edge(input logic ed, input logic start, input int dr,
                           input int di, input string tag);
        int r, i;
        RST       = 1'b0;
        bus.ED    = ed;
        bus.START = start;
        bus.DR    = DW'(dr);
        bus.DI    = DW'(di);
        if (ed) begin
            model(m_addr, dr, di, r, i);
            exp_r[2] = exp_r[1]; exp_r[1] = exp_r[0]; exp_r[0] = r;
            exp_i[2] = exp_i[1]; exp_i[1] = exp_i[0]; exp_i[0] = i;
            exp_rdy  = {exp_rdy[2:0], start};
            m_addr   = start ? 0 : (m_addr + 1) % 64;
        end
        @(posedge CLK);
        #1;
        chk({tag, "_dor"}, bus.DOR, exp_r[2]);
        chk({tag, "_doi"}, bus.DOI, exp_i[2]);
        chk({tag, "_rdy"}, bus.RDY, exp_rdy[3]);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rdy_hits  = 0;
        RST       = 1'b1;
        bus.ED    = 1'b0;
        bus.START = 1'b0;
        bus.DR    = '0;
        bus.DI    = '0;
        for (int m = 0; m <= 16; m++)
            tab[m] = int'(16383.0 * $cos(2.0 * PI * real'(m) / 64.0));
        model_reset();

        // Reset with random inputs, including ED low, then release.
        do_reset(1'b1, "rst_a");
        do_reset(1'b0, "rst_b");
        do_edge(1'b1, 1'b0, 0, 0, "rst_rel");

        // Frame A: constant real input, ED gaps at RDY and after sample 10.
        do_edge(1'b1, 1'b1, 1000, 0, "a_start");
        for (int k = 0; k < 64; k++) begin
            do_edge(1'b1, 1'b0, 1000, 0, "a");
            if (k == 2) begin
                chk("a_s0_rdy", bus.RDY, 1);
                chk("a_s0_dor", bus.DOR, H_E0);
                chk("a_s0_doi", bus.DOI, 0);
                do_edge(1'b0, 1'b0, 7777, -7777, "a_hold_rdy");
                do_edge(1'b0, 1'b0, -5, 5, "a_hold_rdy");
            end
            if (k == 10) begin
                for (int g = 0; g < 5; g++)
                    do_edge(1'b0, g == 2, 3 * g - 40000, 29000 - g, "a_gate");
            end
            if (k == 10) chk("a_s8_dor", bus.DOR, H_E0);
            if (k == 22) begin
                chk("a_s20_dor", bus.DOR, H_E8);
                chk("a_s20_doi", bus.DOI, H_E8);
            end
            if (k == 38) begin
                chk("a_s36_dor", bus.DOR, 0);
                chk("a_s36_doi", bus.DOI, H_E0);
            end
        end

        // Frame B: varied complex input, full-scale sample at index 20.
        do_edge(1'b1, 1'b1, 1000, 0, "b_start");
        for (int k = 0; k < 24; k++) begin
            if (k == 20)
                do_edge(1'b1, 1'b0, -131072, 131071, "b");
            else
                do_edge(1'b1, 1'b0, 500 * k - 6000, 4000 - 250 * k, "b");
            if (k == 2) chk("b_s0_rdy", bus.RDY, 1);
            if (k == 22) begin
                chk("b_xtr_dor", bus.DOR, H_XR);
                chk("b_xtr_doi", bus.DOI, H_XI);
            end
        end

        // Frame C: START after sample 10, then run through two wraps.
        do_edge(1'b1, 1'b1, 0, 1000, "c_start");
        for (int k = 0; k <= 10; k++)
            do_edge(1'b1, 1'b0, 0, 1000, "c");
        do_edge(1'b1, 1'b1, 0, 1000, "c_restart");
        for (int n = 1; n <= 130; n++) begin
            do_edge(1'b1, 1'b0, 0, 1000, "c_run");
            if (bus.RDY === 1'b1) rdy_hits++;
            if (n == 3) begin
                chk("c_e0_rdy", bus.RDY, 1);
                chk("c_e0_dor", bus.DOR, 0);
                chk("c_e0_doi", bus.DOI, H_E0);
            end
        end
        chk("c_rdy_once", rdy_hits, 1);

        // Reset in the middle of a frame discards in-flight data.
        do_edge(1'b1, 1'b1, 20000, -20000, "d_start");
        do_edge(1'b1, 1'b0, 20000, -20000, "d");
        do_edge(1'b1, 1'b0, 20000, -20000, "d");
        do_reset(1'b1, "d_rst");
        do_edge(1'b1, 1'b0, 0, 0, "d_rel");
        do_edge(1'b1, 1'b0, 0, 0, "d_rel");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
